// File: rtl/dpb_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Each access takes IDLE -> ISSUE (ce/ack) -> CAPTURE (read data lands) -> IDLE.
module dpb_port_arbiter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                win_q, win_d;      // requester owning the access in flight
  logic                last_q, last_d;    // requester granted most recently
  logic                rd_q, rd_d;        // access in flight is a read
  logic                ram_ce_q, ram_ce_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_ad_q, ram_ad_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                pick1;

  // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
  assign pick1 = req1 & (~req0 | ~last_q);

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    last_d    = last_q;
    rd_d      = rd_q;
    ram_ad_d  = ram_ad_q;
    ram_din_d = ram_din_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    ram_ce_d  = 1'b0;
    ram_we_d  = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          win_d     = pick1;
          last_d    = pick1;
          rd_d      = pick1 ? ~we1 : ~we0;
          ram_we_d  = pick1 ? we1 : we0;
          ram_ad_d  = pick1 ? addr1 : addr0;
          ram_din_d = pick1 ? wdata1 : wdata0;
          ram_ce_d  = 1'b1;
          ack0_d    = ~pick1;
          ack1_d    = pick1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // RAM output is valid in this cycle; latch it for the winner on exit.
        if (rd_q) begin
          if (win_q) begin
            rdata1_d  = ram_dout;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = ram_dout;
            rvalid0_d = 1'b1;
          end
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      win_q     <= 1'b0;
      last_q    <= 1'b1;
      rd_q      <= 1'b0;
      ram_ce_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      ram_ad_q  <= '0;
      ram_din_q <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      last_q    <= last_d;
      rd_q      <= rd_d;
      ram_ce_q  <= ram_ce_d;
      ram_we_q  <= ram_we_d;
      ram_ad_q  <= ram_ad_d;
      ram_din_q <= ram_din_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign ram_ce  = ram_ce_q;
  assign ram_we  = ram_we_q;
  assign ram_ad  = ram_ad_q;
  assign ram_din = ram_din_q;

endmodule

// File: tb/tb_dpb_port_arbiter.sv
// Bench for dpb_port_arbiter: a behavioural RAM, directed scenarios and a
// randomized run checked against a cycle-timeline model of the arbiter.
module tb_dpb_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, we0, we1;
  logic [8:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       ram_ce, ram_we;
  logic [8:0] ram_ad;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  logic [7:0] mem [0:511];
  logic [7:0] ref_mem [0:511];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dpb_port_arbiter #(.ADDR_W(9), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_ad(ram_ad), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Synchronous single-port RAM: read data appears the cycle after ce.
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_ad] <= ram_din;
      else        ram_dout    <= mem[ram_ad];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Drives one access and returns whether it was acked and the rdata seen
  // in the rvalid cycle; callers do the comparing.
  task automatic do_access(input bit port, input logic w, input logic [8:0] a,
                           input logic [7:0] d, output bit got_ack, output logic [7:0] rd);
    if (!port) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else       begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    got_ack = 1'b0;
    for (int i = 0; i < 8 && !got_ack; i++) begin
      tick();
      if (port ? ack1 : ack0) got_ack = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    rd = port ? rdata1 : rdata0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({ack0, ack1, rvalid0, rvalid1, ram_ce, ram_we} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000000", {ack0, ack1, rvalid0, rvalid1, ram_ce, ram_we});
    end
    checks++;
    if ({ram_ad, ram_din, rdata0, rdata1} !== 33'd0) begin
      failures++;
      $display("FAIL reset_data ad=%h din=%h rd0=%h rd1=%h want all 0", ram_ad, ram_din, rdata0, rdata1);
    end
    tick();
    checks++;
    if ({ack0, ack1, ram_ce} !== 3'b0) begin
      failures++;
      $display("FAIL idle_no_req got=%b want=000", {ack0, ack1, ram_ce});
    end
  endtask

  task automatic test_single_read();
    mem[9'h1A5] = 8'h5C;
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h1A5; wdata0 = 8'($urandom);
    tick();
    checks++;
    if ({ack0, ack1, ram_ce, ram_we} !== 4'b1010 || ram_ad !== 9'h1A5) begin
      failures++;
      $display("FAIL read_issue ack0/ack1/ce/we=%b ad=%h want 1010 ad=1a5", {ack0, ack1, ram_ce, ram_we}, ram_ad);
    end
    req0 = 1'b0;
    tick();
    checks++;
    if ({rvalid0, ram_ce, ram_we, ack0} !== 4'b0) begin
      failures++;
      $display("FAIL read_capture rv0/ce/we/ack0=%b want 0000", {rvalid0, ram_ce, ram_we, ack0});
    end
    tick();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'h5C || rvalid1 !== 1'b0) begin
      failures++;
      $display("FAIL read_rvalid rv0=%b rv1=%b rd0=%h want 1 0 5c", rvalid0, rvalid1, rdata0);
    end
    tick();
    checks++;
    if (rvalid0 !== 1'b0 || rdata0 !== 8'h5C) begin
      failures++;
      $display("FAIL read_hold rv0=%b rd0=%h want 0 5c", rvalid0, rdata0);
    end
  endtask

  task automatic test_write_read();
    int n;
    req1 = 1'b1; we1 = 1'b1; addr1 = 9'h0FF; wdata1 = 8'hA3;
    tick();
    checks++;
    if ({ack1, ack0, ram_ce, ram_we} !== 4'b1011 || ram_din !== 8'hA3 || ram_ad !== 9'h0FF) begin
      failures++;
      $display("FAIL write_issue ack1/ack0/ce/we=%b ad=%h din=%h want 1011 0ff a3",
               {ack1, ack0, ram_ce, ram_we}, ram_ad, ram_din);
    end
    we1 = 1'b0; wdata1 = 8'h00;
    n = 0;
    do begin
      tick();
      n++;
      checks++;
      if (rvalid1 !== 1'b0) begin
        failures++;
        $display("FAIL write_no_rvalid rv1=%b want 0 at step %0d", rvalid1, n);
      end
    end while (!ack1 && n < 6);
    checks++;
    if (!ack1 || n != 3) begin
      failures++;
      $display("FAIL ack_spacing got=%0d cycles ack1=%b want 3 cycles", n, ack1);
    end
    req1 = 1'b0;
    tick();
    tick();
    checks++;
    if (rvalid1 !== 1'b1 || rdata1 !== 8'hA3) begin
      failures++;
      $display("FAIL write_then_read rv1=%b rd1=%h want 1 a3", rvalid1, rdata1);
    end
  endtask

  task automatic test_contention();
    logic e0, e1;
    idle_inputs();
    reset = 1'b1;
    req0 = 1'b1; addr0 = 9'h010;
    req1 = 1'b1; addr1 = 9'h020;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      e0 = (i % 6 == 1);
      e1 = (i % 6 == 4);
      checks++;
      if ({ack0, ack1} !== {e0, e1}) begin
        failures++;
        $display("FAIL contention cycle=%0d ack0/ack1=%b want %b", i, {ack0, ack1}, {e0, e1});
      end
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_overlap();
    mem[9'h033] = 8'h77;
    mem[9'h044] = 8'h3E;
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h033;
    tick();
    checks++;
    if (ack0 !== 1'b1) begin
      failures++;
      $display("FAIL overlap_ack0 got=%b want 1", ack0);
    end
    req0 = 1'b0;
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'h044;
    tick();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'h77 || ack1 !== 1'b0) begin
      failures++;
      $display("FAIL overlap_rvalid rv0=%b rd0=%h ack1=%b want 1 77 0", rvalid0, rdata0, ack1);
    end
    tick();
    checks++;
    if (ack1 !== 1'b1 || ram_ad !== 9'h044 || rvalid0 !== 1'b0) begin
      failures++;
      $display("FAIL overlap_ack1 ack1=%b ad=%h rv0=%b want 1 044 0", ack1, ram_ad, rvalid0);
    end
    req1 = 1'b0;
    tick();
    tick();
    checks++;
    if (rvalid1 !== 1'b1 || rdata1 !== 8'h3E) begin
      failures++;
      $display("FAIL overlap_rd1 rv1=%b rd1=%h want 1 3e", rvalid1, rdata1);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    mem[9'h055] = 8'h99;
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h055;
    tick();
    checks++;
    if (ack0 !== 1'b1 || ram_ce !== 1'b1) begin
      failures++;
      $display("FAIL mid_issue ack0=%b ce=%b want 1 1", ack0, ram_ce);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ack0, ack1, rvalid0, rvalid1, ram_ce, ram_we} !== 6'b0 || ram_ad !== 9'h000 || rdata0 !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset ctrl=%b ad=%h rd0=%h want 000000 000 00",
               {ack0, ack1, rvalid0, rvalid1, ram_ce, ram_we}, ram_ad, rdata0);
    end
    req0 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rvalid0 || rvalid1 || ack0 || ack1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL mid_aftermath got=1 want no ack/rvalid after reset");
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h055;
    tick();
    checks++;
    if (ack0 !== 1'b1) begin
      failures++;
      $display("FAIL mid_resume_ack got=%b want 1", ack0);
    end
    req0 = 1'b0;
    tick();
    tick();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'h99) begin
      failures++;
      $display("FAIL mid_resume_data rv0=%b rd0=%h want 1 99", rvalid0, rdata0);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0] rd;
    do_access(1'b0, 1'b1, 9'h000, 8'h11, ok, rd);
    checks++;
    if (!ok) begin failures++; $display("FAIL wrap_wr0 ack=0 want 1"); end
    do_access(1'b0, 1'b1, 9'h1FF, 8'hEE, ok, rd);
    checks++;
    if (!ok) begin failures++; $display("FAIL wrap_wr1ff ack=0 want 1"); end
    do_access(1'b0, 1'b0, 9'h000, 8'h00, ok, rd);
    checks++;
    if (!ok || rd !== 8'h11) begin
      failures++;
      $display("FAIL wrap_rd0 ack=%b rd=%h want 1 11", ok, rd);
    end
    do_access(1'b1, 1'b0, 9'h1FF, 8'h00, ok, rd);
    checks++;
    if (!ok || rd !== 8'hEE) begin
      failures++;
      $display("FAIL wrap_rd1ff ack=%b rd=%h want 1 ee", ok, rd);
    end
    do_access(1'b1, 1'b0, 9'h0FF, 8'h00, ok, rd);
    checks++;
    if (!ok || rd !== 8'hA3) begin
      failures++;
      $display("FAIL wrap_alias0ff ack=%b rd=%h want 1 a3", ok, rd);
    end
  endtask

  // Timeline model: the arbiter can take a new grant 3 edges after the last
  // one; a read's data is visible 2 cycles after its ack.
  task automatic test_random();
    bit         p0, p1, w0, w1, lastg, g;
    logic [8:0] a0, a1;
    logic [7:0] d0, d1, v;
    logic [7:0] rv0_d, rv1_d;
    logic [3:0] r;
    bit         e0, e1;
    int         cyc, free_at, rv0_at, rv1_at;

    for (int i = 0; i < 512; i++) begin
      v = 8'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    apply_reset();
    p0 = 0; p1 = 0; w0 = 0; w1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    lastg = 1'b1; cyc = 0; free_at = 0; rv0_at = -1; rv1_at = -1;
    rv0_d = '0; rv1_d = '0;

    for (int n = 0; n < 400; n++) begin
      if (!p0 && $urandom_range(0, 2) == 0) begin
        r = 4'($urandom);
        p0 = 1; w0 = 1'($urandom); d0 = 8'($urandom);
        a0 = (r[0] ? 9'h1F8 : 9'h000) | {6'd0, r[3:1]};
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        r = 4'($urandom);
        p1 = 1; w1 = 1'($urandom); d1 = 8'($urandom);
        a1 = (r[0] ? 9'h1F8 : 9'h000) | {6'd0, r[3:1]};
      end
      req0 = p0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = p1; we1 = w1; addr1 = a1; wdata1 = d1;
      tick();
      cyc++;

      e0 = 0; e1 = 0;
      if (cyc >= free_at && (p0 || p1)) begin
        g = (p0 && p1) ? ~lastg : p1;
        lastg = g;
        free_at = cyc + 3;
        if (!g) begin
          e0 = 1;
          checks++;
          if (ram_ad !== a0 || ram_we !== w0 || (w0 && ram_din !== d0)) begin
            failures++;
            $display("FAIL rand_bus0 cyc=%0d ad=%h we=%b din=%h want %h %b %h", cyc, ram_ad, ram_we, ram_din, a0, w0, d0);
          end
          if (w0) ref_mem[a0] = d0;
          else begin rv0_at = cyc + 2; rv0_d = ref_mem[a0]; end
          p0 = 0;
        end else begin
          e1 = 1;
          checks++;
          if (ram_ad !== a1 || ram_we !== w1 || (w1 && ram_din !== d1)) begin
            failures++;
            $display("FAIL rand_bus1 cyc=%0d ad=%h we=%b din=%h want %h %b %h", cyc, ram_ad, ram_we, ram_din, a1, w1, d1);
          end
          if (w1) ref_mem[a1] = d1;
          else begin rv1_at = cyc + 2; rv1_d = ref_mem[a1]; end
          p1 = 0;
        end
      end

      checks++;
      if ({ack0, ack1, ram_ce} !== {e0, e1, e0 | e1}) begin
        failures++;
        $display("FAIL rand_ack cyc=%0d ack0/ack1/ce=%b want %b", cyc, {ack0, ack1, ram_ce}, {e0, e1, e0 | e1});
      end
      checks++;
      if (rvalid0 !== (rv0_at == cyc) || (rv0_at == cyc && rdata0 !== rv0_d)) begin
        failures++;
        $display("FAIL rand_rv0 cyc=%0d rv0=%b rd0=%h want %b %h", cyc, rvalid0, rdata0, rv0_at == cyc, rv0_d);
      end
      checks++;
      if (rvalid1 !== (rv1_at == cyc) || (rv1_at == cyc && rdata1 !== rv1_d)) begin
        failures++;
        $display("FAIL rand_rv1 cyc=%0d rv1=%b rd1=%h want %b %h", cyc, rvalid1, rdata1, rv1_at == cyc, rv1_d);
      end
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    ram_dout = '0;
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_overlap();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpb_port_arbiter.md
DPB_PORT_ARBITER -- requirements
Module: dpb_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, RAM port address width (512 words).
REQ-002 The block SHALL have parameter DATA_W, default 8, RAM port data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have ports req0/req1, input, 1 each, access request, level, held until ack.
REQ-006 The block SHALL have ports we0/we1, input, 1 each: 1 = write, 0 = read; valid while reqN=1.
REQ-007 The block SHALL have ports addr0/addr1, input, ADDR_W each, access address; valid while reqN=1.
REQ-008 The block SHALL have ports wdata0/wdata1, input, DATA_W each, write data; valid while reqN=1.
REQ-009 The block SHALL have ports ack0/ack1, output, 1 each, one-cycle pulse marking that the request was issued to RAM.
REQ-010 The block SHALL have ports rvalid0/rvalid1, output, 1 each, one-cycle pulse marking that rdataN holds fresh read data.
REQ-011 The block SHALL have ports rdata0/rdata1, output, DATA_W each, last read data per requester, held between reads.
REQ-012 The block SHALL have ports ram_ce, ram_we, output, 1 each, RAM port clock-enable and write-enable.
REQ-013 The block SHALL have ports ram_ad (ADDR_W) and ram_din (DATA_W), output, RAM port address and write data.
REQ-014 The block SHALL have port ram_dout, input, DATA_W, RAM port read data, valid the cycle after the RAM samples ce=1 with we=0.

Function
REQ-015 The block SHALL implement FSM states IDLE, ISSUE, CAPTURE.
REQ-016 In IDLE with no request, the block SHALL stay in IDLE.
REQ-017 In IDLE with any reqN=1 at a rising edge, the block SHALL register the winner's we/addr/wdata into ram_we/ram_ad/ram_din, record the winner, and enter ISSUE.
REQ-018 Arbitration SHALL be round-robin: a single requester wins; if both request, the requester not granted last wins.
REQ-019 In ISSUE, the block SHALL drive ram_ce=1 and ackN=1 for the winner only, all for exactly one cycle, then enter CAPTURE.
REQ-020 In CAPTURE, ram_ce and ram_we SHALL be 0.
REQ-021 If the access was a read, the block SHALL load ram_dout into the winner's rdataN at the edge ending CAPTURE and pulse its rvalidN for the following cycle.
REQ-022 The edge ending CAPTURE SHALL return the FSM to IDLE.
REQ-023 A write SHALL never assert rvalidN nor alter rdataN.
REQ-024 Total latency SHALL be: request sampled at edge E; ack in cycle E+1; rvalid in cycle E+3; maximum throughput one access per 3 cycles.
REQ-025 Requesters drop req or present a new access at the edge ending the ack cycle; reqN is not sampled in ISSUE or CAPTURE, so no double grant occurs.
REQ-026 rvalidN of a completed read and the IDLE acceptance of a new request SHALL occur in the same cycle without interference.
REQ-027 A request arriving while the other requester is being served SHALL be held pending and served next.
REQ-028 ram_ad and ram_din SHALL hold their last values outside ISSUE.

Reset
REQ-029 Asserting reset SHALL asynchronously force state IDLE; ram_ce, ram_we, ackN and rvalidN to 0; ram_ad, ram_din and rdataN to 0; last-grant to requester 1, so requester 0 wins the first tie.
REQ-030 Reset during ISSUE or CAPTURE SHALL abort the access with no ack or rvalid after reset; a write already sampled by the RAM is not undone.

Verification
REQ-031 Single read: req0=1, we0=0, addr0=0x1A5, RAM holds 0x5C -> ack0 in cycle E+1 with ram_ad=0x1A5, ram_ce=1; rvalid0 in E+3 with rdata0=0x5C.
REQ-032 Write then read: req1 write 0x0FF <- 0xA3, then req1 read 0x0FF -> two ack1 pulses 3 cycles apart; rvalid1 with rdata1=0xA3.
REQ-033 Contention: req0 and req1 both asserted continuously from reset release -> acks alternate 0,1,0,1 every 3 cycles; neither requester starves.
REQ-034 Overlap: req1 asserts during req0's CAPTURE -> rvalid0 and the IDLE acceptance of req1 in the same cycle; ack1 follows one cycle later.
REQ-035 Reset mid-access: reset pulsed in ISSUE of a read -> all outputs 0 immediately; no rvalid after release; the next request is served normally.
REQ-036 Address wrap: reads at 0x000 and 0x1FF return the values written there, with no aliasing.
